// File: rtl/complete_route_ctrl.sv
// Valve sequencer for a K_N fluidic fabric: opens the one valve joining src/dst,
// dwells, closes, settles, then reports done. Optional abort input: ROUTE_ABORT_EN.
module complete_route_ctrl #(
  parameter int N_PORTS = 8,
  parameter int PW      = $clog2(N_PORTS),
  parameter int NE      = N_PORTS * (N_PORTS - 1) / 2,
  parameter int HOLD_W  = 8,
  parameter int SETTLE  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ROUTE_ABORT_EN
  input  logic              abort_i,
`endif
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [PW-1:0]     req_src_i,
  input  logic [PW-1:0]     req_dst_i,
  input  logic [HOLD_W-1:0] req_hold_i,
  output logic [NE-1:0]     valve_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [HOLD_W-1:0] SETTLE_M1 = HOLD_W'(SETTLE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OPEN  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_CLOSE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NE-1:0]     valve_q, valve_d;
  logic              busy_q, done_q, done_d, err_q, err_d;
  logic              live_q;
  logic              abort_w;
  logic              req_ok;

`ifdef ROUTE_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  // Triangular numbering of unordered pairs (a<b): row a starts at a*(2N-a-1)/2.
  function automatic logic [IW-1:0] edge_idx(input logic [PW-1:0] p, input logic [PW-1:0] q);
    int a;
    int b;
    a = (p < q) ? int'(p) : int'(q);
    b = (p < q) ? int'(q) : int'(p);
    return IW'((a * (2 * N_PORTS - a - 1)) / 2 + (b - a - 1));
  endfunction

  assign req_ok = (req_src_i != req_dst_i) &&
                  (int'(req_src_i) < N_PORTS) && (int'(req_dst_i) < N_PORTS);

  // live_q keeps the controller from accepting in the first cycle after reset.
  assign req_ready_o = live_q && (state_q == S_IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          if (req_ok) begin
            state_d = S_OPEN;
            cnt_d   = SETTLE_M1;
            hold_d  = req_hold_i;
            idx_d   = edge_idx(req_src_i, req_dst_i);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_OPEN: begin
        if (abort_w || (cnt_q == '0 && hold_q == '0)) begin
          state_d = S_CLOSE;
          cnt_d   = SETTLE_M1;
        end else if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = hold_q - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (abort_w || cnt_q == '0) begin
          state_d = S_CLOSE;
          cnt_d   = SETTLE_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CLOSE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valve drive follows the next state so it is registered with no extra latency.
  assign valve_d = (state_d == S_OPEN || state_d == S_HOLD) ? (NE'(1) << idx_d) : '0;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      // NOTE: everything here is a small register, not a memory, so all of it is reset.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      valve_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      valve_q <= valve_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  assign valve_en_o = valve_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
